// File: rtl/addsub_pkg.sv
// Shared types for the add/sub sequencer: opcodes, FSM states and result flags.
package addsub_pkg;

  localparam int unsigned ADDSUB_WIDTH_DEFAULT = 16;

  // Opcode encoding as seen on in_op
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,  // A + B
    OP_SUB = 2'b01,  // A - B
    OP_BA  = 2'b10,  // B - 2A, two passes
    OP_ACC = 2'b11   // acc + A
  } op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEP1 = 2'b01,
    STEP2 = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Result status flags
  typedef struct packed {
    logic c;  // carry out of the final pass (subtract: 1 = no borrow)
    logic v;  // signed overflow
    logic z;  // result is zero
    logic n;  // result sign bit
  } flags_t;

endpackage : addsub_pkg

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor: s = x + y, or x + ~y + 1 when sub=1.
module addsub_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   sum;

  // Invert-and-carry subtract: the same adder serves both directions
  assign y_eff = sub ? ~y : y;
  assign sum   = {1'b0, x} + {1'b0, y_eff} + (WIDTH+1)'(sub);

  assign s = sum[WIDTH-1:0];
  assign c = sum[WIDTH];

  // Overflow: both effective operands share a sign that the result does not
  assign v = (x[WIDTH-1] == y_eff[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);

endmodule : addsub_core

// File: rtl/addsub_sequencer.sv
// Handshaked add/sub front end running one or two passes through a single
// shared adder. Ops: A+B, A-B, B-2A (two passes) and running accumulate.
// Optional build macro ADDSUB_SAT_EN: saturate results on signed overflow.
module addsub_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  import addsub_pkg::*;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] t_r;    // BA intermediate B-A
  logic             v1_r;   // BA first-pass overflow
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] s_r;
  flags_t           flags_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_sub;
  logic [WIDTH-1:0] core_s;
  logic             core_c;
  logic             core_v;
  logic [WIDTH-1:0] res;
  logic             fin_v;
  flags_t           fin_flags;
  logic             accept;

  // Input handshake: ready when idle, or when the held result leaves this cycle
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Operand routing into the shared adder for the current pass
  always_comb begin
    core_x   = '0;
    core_y   = '0;
    core_sub = 1'b0;
    case (state)
      STEP1: begin
        case (op_r)
          OP_ADD: begin
            core_x = a_r;
            core_y = b_r;
          end
          OP_SUB: begin
            core_x   = a_r;
            core_y   = b_r;
            core_sub = 1'b1;
          end
          OP_BA: begin
            core_x   = b_r;
            core_y   = a_r;
            core_sub = 1'b1;
          end
          OP_ACC: begin
            core_x = acc;
            core_y = a_r;
          end
          default: ;
        endcase
      end
      STEP2: begin
        core_x   = t_r;
        core_y   = a_r;
        core_sub = 1'b1;
      end
      default: ;
    endcase
  end

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x   (core_x),
    .y   (core_y),
    .sub (core_sub),
    .s   (core_s),
    .c   (core_c),
    .v   (core_v)
  );

`ifdef ADDSUB_SAT_EN
  // On overflow the true result carries the sign shared by both operands
  assign res = core_v ? (core_x[WIDTH-1] ? SMIN : SMAX) : core_s;
`else
  // Wrap-around modulo 2^WIDTH; overflow is only reported
  assign res = core_s;
  logic unused_sat;
  assign unused_sat = ^{SMAX, SMIN};
`endif

  // Final-pass flags; BA overflow accumulates over both passes
  always_comb begin
    fin_v       = core_v || ((state == STEP2) && v1_r);
    fin_flags   = '0;
    fin_flags.c = core_c;
    fin_flags.v = fin_v;
    fin_flags.z = (res == '0);
    fin_flags.n = res[WIDTH-1];
  end

  // Sequencer FSM with registered result, flags and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= OP_ADD;
      a_r         <= '0;
      b_r         <= '0;
      t_r         <= '0;
      v1_r        <= 1'b0;
      acc         <= '0;
      s_r         <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= op_t'(in_op);
            a_r   <= in_a;
            b_r   <= in_b;
            state <= STEP1;
          end
        end
        STEP1, STEP2: begin
          if ((state == STEP1) && (op_r == OP_BA)) begin
            t_r   <= res;
            v1_r  <= core_v;
            state <= STEP2;
          end else begin
            s_r         <= res;
            acc         <= res;
            flags_r     <= fin_flags;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (accept) begin
              op_r  <= op_t'(in_op);
              a_r   <= in_a;
              b_r   <= in_b;
              state <= STEP1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_s     = s_r;
  assign out_c     = flags_r.c;
  assign out_v     = flags_r.v;
  assign out_z     = flags_r.z;
  assign out_n     = flags_r.n;

endmodule : addsub_sequencer

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer.
module tb_addsub_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_c;
  logic         out_v;
  logic         out_z;
  logic         out_n;

  int checks = 0;
  int errors = 0;

  addsub_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  // {s, c, v, z, n} packed for one-shot result comparisons
  function automatic logic [W+3:0] result_word();
    return {out_s, out_c, out_v, out_z, out_n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, return cycles from accept edge to out_valid (-1 on timeout)
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (result_word() !== {16'h0000, 4'b0000}) begin
      errors++;
      $display("FAIL reset_result got %h exp %h", result_word(), {16'h0000, 4'b0000});
    end
  endtask

  task automatic test_add();
    int lat;
    logic [W+3:0] exp;
`ifdef ADDSUB_SAT_EN
    exp = {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp = {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    out_ready = 1'b1;
    do_op(2'b00, 16'h7FFF, 16'h0001, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency got %0d exp 2", lat);
    end
    checks++;
    if (result_word() !== exp) begin
      errors++;
      $display("FAIL add_overflow got %h exp %h", result_word(), exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_drain got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(2'b01, 16'h0005, 16'h0007, lat);
    checks++;
    if (result_word() !== {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1} || lat !== 2) begin
      errors++;
      $display("FAIL sub_neg got %h lat %0d exp %h lat 2", result_word(), lat,
               {16'hFFFE, 4'b0001});
    end
    tick();
    do_op(2'b01, 16'h1234, 16'h1234, lat);
    checks++;
    if (result_word() !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero got %h exp %h", result_word(), {16'h0000, 4'b1010});
    end
    tick();
  endtask

  task automatic test_ba();
    int lat;
    // 10-3=7, 7-3=4: both passes without borrow
    do_op(2'b10, 16'h0003, 16'h000A, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL ba_latency got %0d exp 3", lat);
    end
    checks++;
    if (result_word() !== {16'h0004, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ba_small got %h exp %h", result_word(), {16'h0004, 4'b1000});
    end
    tick();
    // 0-16=0xFFF0, then 0xFFF0-0x0010=0xFFE0; the final pass has no unsigned borrow
    do_op(2'b10, 16'h0010, 16'h0000, lat);
    checks++;
    if (result_word() !== {16'hFFE0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ba_neg got %h exp %h", result_word(), {16'hFFE0, 4'b1001});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    do_op(2'b00, 16'h0100, 16'h0023, lat);
    // Hold off the consumer while a competing request is presented and ignored
    in_op    = 2'b01;
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result_word() !== {16'h0123, 4'b0000}) begin
        errors++;
        $display("FAIL hold_cycle%0d got valid=%b ready=%b res=%h exp valid=1 ready=0 res=%h",
                 i, out_valid, in_ready, result_word(), {16'h0123, 4'b0000});
      end
      tick();
    end
    // Release the consumer and offer a new op in the same cycle
    in_a      = 16'h0010;
    in_b      = 16'h0001;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_step1 got valid=%b ready=%b exp valid=0 ready=0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || result_word() !== {16'h000F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result got valid=%b res=%h exp valid=1 res=%h", out_valid,
               result_word(), {16'h000F, 4'b1000});
    end
    tick();
  endtask

  task automatic test_acc();
    int lat;
    apply_reset();
    out_ready = 1'b1;
    do_op(2'b11, 16'h0005, 16'hFFFF, lat);
    checks++;
    if (result_word() !== {16'h0005, 4'b0000} || lat !== 2) begin
      errors++;
      $display("FAIL acc_first got %h lat %0d exp %h lat 2", result_word(), lat,
               {16'h0005, 4'b0000});
    end
    // Issued while the first result is leaving: must see the updated accumulator
    do_op(2'b11, 16'h0005, 16'h1234, lat);
    checks++;
    if (result_word() !== {16'h000A, 4'b0000} || lat !== 2) begin
      errors++;
      $display("FAIL acc_second got %h lat %0d exp %h lat 2", result_word(), lat,
               {16'h000A, 4'b0000});
    end
    tick();
  endtask

  task automatic test_rst_mid_ba();
    int lat;
    do_op(2'b00, 16'h0001, 16'h0002, lat);
    tick();
    in_op    = 2'b10;
    in_a     = 16'h0003;
    in_b     = 16'h000A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_word() !== {16'h0000, 4'b0000}) begin
      errors++;
      $display("FAIL rst_mid_ba got valid=%b ready=%b res=%h exp valid=0 ready=1 res=0",
               out_valid, in_ready, result_word());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_result got valid=%b exp 0", out_valid);
    end
    // Accumulator must restart from zero, not from the earlier result 3
    do_op(2'b11, 16'h0007, 16'h0000, lat);
    checks++;
    if (result_word() !== {16'h0007, 4'b0000}) begin
      errors++;
      $display("FAIL rst_acc_cleared got %h exp %h", result_word(), {16'h0007, 4'b0000});
    end
    tick();
    test_add();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_ba();
    test_back_to_back();
    test_acc();
    test_rst_mid_ba();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_addsub_sequencer
